// File: rtl/sigmul_arbiter.sv
// Round-robin front door for one shared fixed-latency significand multiplier.
// Define SIGMUL_ZERO_BYPASS_EN to answer zero-operand requests without the multiplier.
module sigmul_arbiter #(
    parameter int SIG_W   = 12,
    parameter int PROD_W  = 24,
    parameter int MUL_LAT = 4
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic [1:0]        req_valid,
    output logic [1:0]        req_ready,
    input  logic [SIG_W-1:0]  req_a0,
    input  logic [SIG_W-1:0]  req_b0,
    input  logic [SIG_W-1:0]  req_a1,
    input  logic [SIG_W-1:0]  req_b1,
    input  logic [1:0]        req_zero,
    output logic [SIG_W-1:0]  mul_a,
    output logic [SIG_W-1:0]  mul_b,
    output logic              mul_azero,
    output logic              mul_bzero,
    output logic              mul_start,
    input  logic [PROD_W-1:0] mul_s,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic              rsp_id,
    output logic [PROD_W-1:0] rsp_s
);

    localparam int CNT_W = 4;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        DONE
    } state_t;

    state_t             state;
    state_t             state_nx;
    logic               rr_ptr;
    logic [CNT_W-1:0]   cnt;
    logic [1:0]         grant;
    logic               acc;
    logic               acc_id;
    logic               zero_sel;
    logic               bypass;
    logic [PROD_W-1:0]  prod_ext;

    // Contested cycles go to the requester rr_ptr points at.
    always_comb begin
        grant[0] = req_valid[0] & (~req_valid[1] | ~rr_ptr);
        grant[1] = req_valid[1] & (~req_valid[0] | rr_ptr);
    end

    assign req_ready = (state == IDLE) ? grant : 2'b00;
    assign acc       = |(req_valid & req_ready);
    assign acc_id    = req_ready[1];
    assign zero_sel  = acc_id ? req_zero[1] : req_zero[0];

`ifdef SIGMUL_ZERO_BYPASS_EN
    assign bypass = zero_sel;
`else
    assign bypass = 1'b0;
`endif

    always_comb begin
        prod_ext = '0;
        prod_ext[2*SIG_W-1:0] = mul_s[2*SIG_W-1:0];
    end

    always_comb begin
        state_nx  = state;
        mul_start = 1'b0;
        rsp_valid = 1'b0;
        unique case (state)
            IDLE: begin
                if (acc) state_nx = bypass ? DONE : ISSUE;
            end
            ISSUE: begin
                mul_start = 1'b1;
                state_nx  = WAIT;
            end
            WAIT: begin
                if (cnt == CNT_W'(1)) state_nx = DONE;
            end
            DONE: begin
                rsp_valid = 1'b1;
                if (rsp_ready) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RST) state <= IDLE;
        else      state <= state_nx;
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            rr_ptr    <= 1'b0;
            cnt       <= '0;
            mul_a     <= '0;
            mul_b     <= '0;
            mul_azero <= 1'b0;
            mul_bzero <= 1'b0;
            rsp_id    <= 1'b0;
            rsp_s     <= '0;
        end else begin
            if (acc) begin
                mul_a     <= acc_id ? req_a1 : req_a0;
                mul_b     <= acc_id ? req_b1 : req_b0;
                mul_azero <= zero_sel;
                mul_bzero <= zero_sel;
                rsp_id    <= acc_id;
                rr_ptr    <= ~acc_id;
                if (bypass) rsp_s <= '0;
            end
            // Product is sampled exactly MUL_LAT cycles after the start pulse.
            if (state == ISSUE) begin
                cnt <= CNT_W'(MUL_LAT);
            end else if (state == WAIT) begin
                cnt <= cnt - CNT_W'(1);
                if (cnt == CNT_W'(1)) rsp_s <= prod_ext;
            end
        end
    end

endmodule

// File: tb/tb_sigmul_arbiter.sv
// Directed bench for sigmul_arbiter with a fixed-latency multiplier model.
// Expectations follow SIGMUL_ZERO_BYPASS_EN when it is defined for the build.
module tb_sigmul_arbiter;

    localparam int SIG_W   = 12;
    localparam int PROD_W  = 24;
    localparam int MUL_LAT = 4;

    logic              CLK       = 1'b0;
    logic              RST       = 1'b0;
    logic [1:0]        req_valid = '0;
    logic [1:0]        req_ready;
    logic [SIG_W-1:0]  req_a0    = '0;
    logic [SIG_W-1:0]  req_b0    = '0;
    logic [SIG_W-1:0]  req_a1    = '0;
    logic [SIG_W-1:0]  req_b1    = '0;
    logic [1:0]        req_zero  = '0;
    logic [SIG_W-1:0]  mul_a;
    logic [SIG_W-1:0]  mul_b;
    logic              mul_azero;
    logic              mul_bzero;
    logic              mul_start;
    logic [PROD_W-1:0] mul_s;
    logic              rsp_valid;
    logic              rsp_ready = 1'b0;
    logic              rsp_id;
    logic [PROD_W-1:0] rsp_s;

    int tests  = 0;
    int fails  = 0;
    int cyc    = 0;
    int starts = 0;
    bit rr_bad = 1'b0;

    bit                acc_q[$];
    int                acc_cyc_q[$];
    bit                rid_q[$];
    logic [PROD_W-1:0] rs_q[$];

    logic [MUL_LAT-1:0] sh     = '0;
    logic [PROD_W-1:0]  prod_r = '0;

    sigmul_arbiter #(
        .SIG_W  (SIG_W),
        .PROD_W (PROD_W),
        .MUL_LAT(MUL_LAT)
    ) dut (
        .CLK      (CLK),
        .RST      (RST),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_a0   (req_a0),
        .req_b0   (req_b0),
        .req_a1   (req_a1),
        .req_b1   (req_b1),
        .req_zero (req_zero),
        .mul_a    (mul_a),
        .mul_b    (mul_b),
        .mul_azero(mul_azero),
        .mul_bzero(mul_bzero),
        .mul_start(mul_start),
        .mul_s    (mul_s),
        .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready),
        .rsp_id   (rsp_id),
        .rsp_s    (rsp_s)
    );

    always #5 CLK = ~CLK;

    // Multiplier model: product only valid MUL_LAT cycles after start.
    always @(posedge CLK) begin
        sh <= (sh << 1) | {{(MUL_LAT-1){1'b0}}, mul_start};
        if (mul_start) prod_r <= PROD_W'(mul_a) * PROD_W'(mul_b);
    end

    assign mul_s = sh[MUL_LAT-1] ? prod_r : PROD_W'(24'hBAD0AD);

    always @(posedge CLK) begin
        cyc <= cyc + 1;
        if (RST) begin
            if (|(req_valid & req_ready)) begin
                acc_q.push_back(req_ready[1]);
                acc_cyc_q.push_back(cyc);
            end
            if (mul_start) starts <= starts + 1;
            if (req_ready == 2'b11) rr_bad <= 1'b1;
            if (rsp_valid && rsp_ready) begin
                rid_q.push_back(rsp_id);
                rs_q.push_back(rsp_s);
            end
        end
    end

    task automatic tick;
        @(posedge CLK);
        #1;
    endtask

    task automatic clear_mon;
        acc_q.delete();
        acc_cyc_q.delete();
        rid_q.delete();
        rs_q.delete();
        rr_bad = 1'b0;
    endtask

    task automatic do_accept(input bit id, input logic [SIG_W-1:0] a,
                             input logic [SIG_W-1:0] b, input bit z);
        if (id) begin
            req_a1    = a;
            req_b1    = b;
            req_valid = 2'b10;
            req_zero  = {z, 1'b0};
        end else begin
            req_a0    = a;
            req_b0    = b;
            req_valid = 2'b01;
            req_zero  = {1'b0, z};
        end
        tick;
        req_valid = 2'b00;
        req_zero  = 2'b00;
    endtask

    // Edges after the accept edge until rsp_valid is seen; 40 means timeout.
    task automatic wait_valid(output int lat);
        lat = 0;
        while (!rsp_valid && lat < 40) begin
            tick;
            lat++;
        end
    endtask

    task automatic test_reset;
        RST = 1'b0;
        tick;
        tick;
        tests++;
        if (req_ready !== 2'b00 || mul_start !== 1'b0) begin
            fails++;
            $display("FAIL reset_ctl: req_ready=%b mul_start=%b want 00/0",
                     req_ready, mul_start);
        end
        tests++;
        if (mul_a !== '0 || mul_b !== '0 || mul_azero !== 1'b0 || mul_bzero !== 1'b0) begin
            fails++;
            $display("FAIL reset_mul: a=%h b=%h az=%b bz=%b want 0",
                     mul_a, mul_b, mul_azero, mul_bzero);
        end
        tests++;
        if (rsp_valid !== 1'b0 || rsp_id !== 1'b0 || rsp_s !== '0) begin
            fails++;
            $display("FAIL reset_rsp: v=%b id=%b s=%h want 0",
                     rsp_valid, rsp_id, rsp_s);
        end
        RST = 1'b1;
        req_valid = 2'b11;
        #1;
        tests++;
        if (req_ready !== 2'b01) begin
            fails++;
            $display("FAIL reset_rrptr: req_ready=%b want 01", req_ready);
        end
        req_valid = 2'b10;
        #1;
        req_valid = 2'b00;
        clear_mon;
        tick;
        tests++;
        if (acc_q.size() != 0) begin
            fails++;
            $display("FAIL dropped_req: accepts=%0d want 0", acc_q.size());
        end
    endtask

    task automatic test_single;
        int lat;
        int s0;
        clear_mon;
        rsp_ready = 1'b1;
        s0 = starts;
        do_accept(1'b0, 12'h800, 12'h800, 1'b0);
        tests++;
        if (mul_start !== 1'b1 || mul_a !== 12'h800 || mul_b !== 12'h800) begin
            fails++;
            $display("FAIL single_issue: start=%b a=%h b=%h want 1/800/800",
                     mul_start, mul_a, mul_b);
        end
        wait_valid(lat);
        tests++;
        if (lat != MUL_LAT + 1) begin
            fails++;
            $display("FAIL single_lat: got %0d want %0d", lat, MUL_LAT + 1);
        end
        tests++;
        if (rsp_s !== 24'h400000 || rsp_id !== 1'b0) begin
            fails++;
            $display("FAIL single_rsp: s=%h id=%b want 400000/0", rsp_s, rsp_id);
        end
        tests++;
        if (starts - s0 != 1) begin
            fails++;
            $display("FAIL single_starts: got %0d want 1", starts - s0);
        end
        tick;
        tests++;
        if (rsp_valid !== 1'b0 || rs_q.size() != 1) begin
            fails++;
            $display("FAIL single_drain: v=%b rsps=%0d want 0/1",
                     rsp_valid, rs_q.size());
        end
    endtask

    task automatic test_contention;
        bit                exp_id[4];
        logic [PROD_W-1:0] exp_s[4];
        exp_id = '{1'b0, 1'b1, 1'b0, 1'b1};
        exp_s  = '{24'h00000F, 24'h00004D, 24'h00000F, 24'h00004D};
        RST = 1'b0;
        tick;
        RST = 1'b1;
        clear_mon;
        rsp_ready = 1'b1;
        req_a0 = 12'd3;
        req_b0 = 12'd5;
        req_a1 = 12'd7;
        req_b1 = 12'd11;
        req_valid = 2'b11;
        for (int n = 0; n < 80 && rs_q.size() < 4; n++) tick;
        req_valid = 2'b00;
        tick;
        tests++;
        if (acc_q.size() != 4 || rs_q.size() != 4) begin
            fails++;
            $display("FAIL cont_count: accepts=%0d rsps=%0d want 4/4",
                     acc_q.size(), rs_q.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                tests++;
                if (acc_q[i] !== exp_id[i] || rid_q[i] !== exp_id[i] ||
                    rs_q[i] !== exp_s[i]) begin
                    fails++;
                    $display("FAIL cont_%0d: grant=%b id=%b s=%h want %b/%b/%h",
                             i, acc_q[i], rid_q[i], rs_q[i],
                             exp_id[i], exp_id[i], exp_s[i]);
                end
            end
        end
        tests++;
        if (rr_bad !== 1'b0) begin
            fails++;
            $display("FAIL cont_onehot: req_ready was 11");
        end
    endtask

    task automatic test_backpressure;
        int lat;
        int s0;
        clear_mon;
        rsp_ready = 1'b0;
        do_accept(1'b0, 12'h100, 12'h010, 1'b0);
        wait_valid(lat);
        tests++;
        if (lat != MUL_LAT + 1) begin
            fails++;
            $display("FAIL bp_lat: got %0d want %0d", lat, MUL_LAT + 1);
        end
        req_a1 = 12'h00F;
        req_b1 = 12'h00F;
        req_valid = 2'b10;
        s0 = starts;
        for (int i = 0; i < 10; i++) begin
            tests++;
            if (rsp_valid !== 1'b1 || rsp_s !== 24'h001000 || rsp_id !== 1'b0 ||
                req_ready !== 2'b00) begin
                fails++;
                $display("FAIL bp_hold_%0d: v=%b s=%h id=%b rdy=%b want 1/001000/0/00",
                         i, rsp_valid, rsp_s, rsp_id, req_ready);
            end
            tick;
        end
        tests++;
        if (starts != s0) begin
            fails++;
            $display("FAIL bp_starts: got %0d want 0", starts - s0);
        end
        rsp_ready = 1'b1;
        tick;
        tests++;
        if (rsp_valid !== 1'b0 || req_ready !== 2'b10) begin
            fails++;
            $display("FAIL bp_release: v=%b rdy=%b want 0/10", rsp_valid, req_ready);
        end
        tick;
        req_valid = 2'b00;
        tests++;
        if (mul_start !== 1'b1 || mul_a !== 12'h00F) begin
            fails++;
            $display("FAIL bp_next: start=%b a=%h want 1/00F", mul_start, mul_a);
        end
        wait_valid(lat);
        tests++;
        if (rsp_s !== 24'h0000E1 || rsp_id !== 1'b1) begin
            fails++;
            $display("FAIL bp_next_rsp: s=%h id=%b want 0000E1/1", rsp_s, rsp_id);
        end
        tick;
    endtask

    task automatic test_zero_bypass;
        int lat;
        int s0;
        int exp_lat;
        int exp_starts;
`ifdef SIGMUL_ZERO_BYPASS_EN
        exp_lat    = 0;
        exp_starts = 0;
`else
        exp_lat    = MUL_LAT + 1;
        exp_starts = 1;
`endif
        clear_mon;
        rsp_ready = 1'b1;
        s0 = starts;
        do_accept(1'b1, 12'hABC, 12'h000, 1'b1);
        tests++;
        if (mul_azero !== 1'b1 || mul_bzero !== 1'b1 || mul_a !== 12'hABC) begin
            fails++;
            $display("FAIL zero_flags: az=%b bz=%b a=%h want 1/1/ABC",
                     mul_azero, mul_bzero, mul_a);
        end
        wait_valid(lat);
        tests++;
        if (lat != exp_lat) begin
            fails++;
            $display("FAIL zero_lat: got %0d want %0d", lat, exp_lat);
        end
        tests++;
        if (rsp_s !== '0 || rsp_id !== 1'b1) begin
            fails++;
            $display("FAIL zero_rsp: s=%h id=%b want 0/1", rsp_s, rsp_id);
        end
        tests++;
        if (starts - s0 != exp_starts) begin
            fails++;
            $display("FAIL zero_starts: got %0d want %0d", starts - s0, exp_starts);
        end
        tick;
    endtask

    task automatic test_reset_mid_wait;
        int s0;
        int seen;
        clear_mon;
        rsp_ready = 1'b1;
        s0 = starts;
        do_accept(1'b0, 12'd2, 12'd3, 1'b0);
        tick;
        tick;
        RST = 1'b0;
        tick;
        RST = 1'b1;
        tests++;
        if (rsp_valid !== 1'b0 || mul_a !== '0 || mul_start !== 1'b0) begin
            fails++;
            $display("FAIL rst_wait_state: v=%b a=%h start=%b want 0/0/0",
                     rsp_valid, mul_a, mul_start);
        end
        req_valid = 2'b11;
        #1;
        tests++;
        if (req_ready !== 2'b01) begin
            fails++;
            $display("FAIL rst_wait_idle: req_ready=%b want 01", req_ready);
        end
        req_valid = 2'b00;
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            tick;
            if (rsp_valid) seen++;
        end
        tests++;
        if (seen != 0 || rs_q.size() != 0 || starts - s0 != 1) begin
            fails++;
            $display("FAIL rst_wait_quiet: valid_cycles=%0d rsps=%0d starts=%0d want 0/0/1",
                     seen, rs_q.size(), starts - s0);
        end
    endtask

    task automatic test_back_to_back;
        clear_mon;
        rsp_ready = 1'b1;
        req_a0 = 12'hFFF;
        req_b0 = 12'hFFF;
        req_zero = 2'b00;
        req_valid = 2'b01;
        for (int n = 0; n < 40 && acc_q.size() < 2; n++) tick;
        req_valid = 2'b00;
        for (int n = 0; n < 40 && rs_q.size() < 2; n++) tick;
        tests++;
        if (rs_q.size() != 2 || acc_cyc_q.size() != 2) begin
            fails++;
            $display("FAIL b2b_count: rsps=%0d accepts=%0d want 2/2",
                     rs_q.size(), acc_cyc_q.size());
        end else begin
            tests++;
            if (rs_q[0] !== 24'hFFE001 || rs_q[1] !== 24'hFFE001 ||
                rid_q[0] !== 1'b0 || rid_q[1] !== 1'b0) begin
                fails++;
                $display("FAIL b2b_rsp: s=%h,%h id=%b,%b want FFE001/0",
                         rs_q[0], rs_q[1], rid_q[0], rid_q[1]);
            end
            tests++;
            if (acc_cyc_q[1] - acc_cyc_q[0] != MUL_LAT + 3) begin
                fails++;
                $display("FAIL b2b_gap: got %0d want %0d",
                         acc_cyc_q[1] - acc_cyc_q[0], MUL_LAT + 3);
            end
        end
    endtask

    initial begin
        test_reset;
        test_single;
        test_contention;
        test_backpressure;
        test_zero_bypass;
        test_reset_mid_wait;
        test_back_to_back;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
